// File: rtl/branch_predictor_bht.sv
// Branch history table of saturating counters, bimodal or gshare-indexed, with an
// F->X stage register that carries each prediction to resolution.
module branch_predictor_bht #(
  parameter int AWIDTH    = 32,
  parameter int ENTRIES   = 64,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] pc_f,
  input  logic              Br_f,
  input  logic              stall,
  input  logic              flush,
  input  logic              Br_x,
  input  logic              BrTrue,
  output logic              BrPred_f,
  output logic              BrPred_x,
  output logic              mispredict,
  output logic [31:0]       br_count,
  output logic [31:0]       miss_count
);

  localparam int IW = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0] ctr_reg [ENTRIES];
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_next;
  logic [IW-1:0]       ghr_ext;
  logic [IW-1:0]       index_f;
  logic [IW-1:0]       idx_x_reg;
  logic                pred_x_reg;
  logic                valid_x_reg;
  logic                upd;
  logic [31:0]         br_count_reg;
  logic [31:0]         miss_count_reg;
  logic                pc_unused;

  // Only the word-aligned index bits of the PC take part in the lookup.
  assign pc_unused = ^{pc_f[AWIDTH-1:IW+2], pc_f[1:0]};

  assign index_f    = pc_f[IW+1:2] ^ ghr_ext;
  assign BrPred_f   = Br_f & ctr_reg[index_f][CTR_BITS-1];
  assign upd        = Br_x & valid_x_reg & ~stall;
  assign mispredict = Br_x & valid_x_reg & (BrTrue != pred_x_reg);
  assign BrPred_x   = pred_x_reg;
  assign br_count   = br_count_reg;
  assign miss_count = miss_count_reg;
  assign ctr_cur    = ctr_reg[idx_x_reg];

  always_comb begin
    ctr_next = ctr_cur;
    if (BrTrue) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
    end else if (ctr_cur != '0) begin
      ctr_next = ctr_cur - 1'b1;
    end
  end

  // Global history is non-speculative: it only advances when a branch retires.
  generate
    if (HIST_BITS > 0) begin : g_hist
      logic [HIST_BITS-1:0] ghr_reg;
      logic [HIST_BITS-1:0] ghr_next;

      always_comb begin
        ghr_next    = ghr_reg << 1;
        ghr_next[0] = BrTrue;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ghr_reg <= '0;
        end else if (upd) begin
          ghr_reg <= ghr_next;
        end
      end

      always_comb begin
        ghr_ext                  = '0;
        ghr_ext[HIST_BITS-1:0]   = ghr_reg;
      end
    end else begin : g_bimodal
      assign ghr_ext = '0;
    end
  endgenerate

  // A write to the entry being read this cycle is seen by fetch only next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_reg[i] <= CTR_INIT;
    end else if (upd) begin
      ctr_reg[idx_x_reg] <= ctr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_x_reg  <= 1'b0;
      idx_x_reg   <= '0;
      valid_x_reg <= 1'b0;
    end else if (flush) begin
      pred_x_reg  <= 1'b0;
      idx_x_reg   <= '0;
      valid_x_reg <= 1'b0;
    end else if (!stall) begin
      pred_x_reg  <= BrPred_f;
      idx_x_reg   <= index_f;
      valid_x_reg <= Br_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_reg   <= '0;
      miss_count_reg <= '0;
    end else if (upd) begin
      br_count_reg <= br_count_reg + 32'd1;
      if (mispredict) miss_count_reg <= miss_count_reg + 32'd1;
    end
  end

endmodule

// File: doc/branch_predictor_bht.md
BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 SHALL provide parameter AWIDTH, default 32, meaning PC width in bits.
REQ-002 SHALL provide parameter ENTRIES, default 64, meaning number of counter-table entries; a power of 2 of at least 4; IW = log2(ENTRIES).
REQ-003 SHALL provide parameter CTR_BITS, default 2, meaning saturating-counter width; range 1..4.
REQ-004 SHALL provide parameter HIST_BITS, default 0, meaning global-history length; 0 = bimodal mode, 1..IW = gshare mode.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port pc_f  input  AWIDTH  PC of the fetch-stage instruction.
REQ-008 SHALL have port Br_f  input  1  fetch-stage instruction is a conditional branch.
REQ-009 SHALL have port stall  input  1  pipeline stall; the F->X stage register holds.
REQ-010 SHALL have port flush  input  1  pipeline flush; the F->X stage register is cleared.
REQ-011 SHALL have port Br_x  input  1  execute-stage instruction is a conditional branch.
REQ-012 SHALL have port BrTrue  input  1  resolved branch outcome in execute (1 = taken).
REQ-013 SHALL have port BrPred_f  output  1  fetch-stage prediction (1 = taken).
REQ-014 SHALL have port BrPred_x  output  1  prediction carried into the execute stage.
REQ-015 SHALL have port mispredict  output  1  execute-stage branch resolved differently from its prediction.
REQ-016 SHALL have port br_count  output  32  count of resolved branches.
REQ-017 SHALL have port miss_count  output  32  count of mispredicted branches.

Function
REQ-018 SHALL compute index_f = pc_f[IW+1:2] XOR (ghr zero-extended to IW bits); ghr is 0 bits wide when HIST_BITS=0, giving pure PC indexing.
REQ-019 SHALL drive BrPred_f combinationally, zero latency: Br_f AND MSB of counter[index_f].
REQ-020 SHALL hold the F->X stage register (pred_x, idx_x, valid_x), updated on the clock edge with this priority: flush -> all 0; else stall -> hold; else pred_x=BrPred_f, idx_x=index_f, valid_x=Br_f.
REQ-021 SHALL drive BrPred_x = pred_x.
REQ-022 SHALL define upd = Br_x AND valid_x AND NOT stall.
REQ-023 SHALL drive mispredict combinationally as Br_x AND valid_x AND (BrTrue != pred_x).
REQ-024 SHALL, on upd, apply counter[idx_x] +1 if BrTrue, saturating at 2^CTR_BITS-1, else -1, saturating at 0.
REQ-025 SHALL, on upd with HIST_BITS>0, shift ghr left and insert BrTrue at bit 0; ghr is non-speculative and changes only on upd.
REQ-026 SHALL, on upd, increment br_count and, if mispredict, increment miss_count; both wrap modulo 2^32.
REQ-027 SHALL give BrPred_f the pre-update counter value when a same-cycle read and write hit one index; the new value is visible the next cycle.
REQ-028 SHALL perform the update when flush and upd are simultaneous (the X branch still resolves) and still clear the stage register.
REQ-029 SHALL make no table, ghr or counter change when stall=1.

Reset
REQ-030 SHALL, while rst=1 and without waiting for a clock, set every table entry to 2^(CTR_BITS-1)-1 (weakly not-taken), with ghr, pred_x, idx_x, valid_x, br_count and miss_count = 0.
REQ-031 SHALL keep BrPred_x, mispredict, br_count and miss_count at 0 while rst=1; BrPred_f reflects the reset table (0).
REQ-032 SHALL discard any in-flight update when rst asserts mid-operation; no partial state survives.

Verification (ENTRIES=64, CTR_BITS=2, HIST_BITS=0 unless stated)
REQ-033 SHALL cover: reset, then pc_f=0x104 with Br_f=1 -> BrPred_f=0 (counter=1).
REQ-034 SHALL cover: one taken resolve of pc 0x104 -> next fetch of 0x104 gives BrPred_f=1; aliasing pc 0x204 (index 1) also gives 1.
REQ-035 SHALL cover: 4 taken resolves then 1 not-taken -> counter 3 then 2, BrPred_f stays 1; br_count=5.
REQ-036 SHALL cover: pred_x=0 with Br_x=1 and BrTrue=1 -> mispredict=1 and miss_count increments by 1; with stall=1 for 3 cycles, BrPred_x holds and neither counters nor table change.
REQ-037 SHALL cover: flush with Br_f=1 -> next cycle valid_x=0, BrPred_x=0; simultaneous flush+upd still increments br_count.
REQ-038 SHALL cover: HIST_BITS=2 with history T,T -> ghr=2'b11 and pc 0x104 maps to index 2; rst pulsed between clock edges -> all outputs 0 immediately.
